polar_frame_sched: RTL and testbench
====================================

POLAR_FRAME_SCHED -- requirements
Module: polar_frame_sched

Interface
REQ-001 Parameter BITS, default 8, SHALL set block length N; power of two, at least 2.
REQ-002 Parameter WAIT_MAX, default 4, SHALL set the maximum cycles to wait for the transform result.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 start  in  1  SHALL begin a frame when high in IDLE.
REQ-006 frozen_mask  in  N  SHALL mark u[i] frozen when bit i = 1; sampled at start.
REQ-007 in_valid / in_ready / in_bit  in / out / in  1 each  SHALL form the serial info-bit input handshake.
REQ-008 pt_in_valid / pt_u  out  1 / N  SHALL be the request to the transform.
REQ-009 pt_out_valid / pt_x  in  1 / N  SHALL be the transform result.
REQ-010 out_valid / out_ready / out_bit / out_last  out / in / out / out  1 each  SHALL form the serial codeword output handshake.
REQ-011 busy / done / err  out  1 each  SHALL give status: busy = not IDLE; done = 1-cycle pulse at frame end; err = sticky timeout flag.

Function
REQ-012 The FSM SHALL have the states IDLE, LOAD, FIRE, WAIT and DRAIN.
REQ-013 IDLE with start=1 SHALL latch frozen_mask, clear pos, and go to LOAD on the next cycle.
REQ-014 LOAD SHALL visit pos 0..N-1, one position per cycle: frozen -> u[pos]=0 and advance without consuming input; info -> in_ready=1, and u[pos]=in_bit with advance only when in_valid=1.
REQ-015 in_ready SHALL be 0 in every state other than LOAD at an info position.
REQ-016 After pos N-1 is written, the FSM SHALL enter FIRE; LOAD length is N cycles plus input stall cycles.
REQ-017 FIRE SHALL last exactly one cycle with pt_in_valid=1 and pt_u = the assembled vector; pt_u SHALL hold stable until DRAIN.
REQ-018 WAIT SHALL capture pt_x into the output register on the first cycle pt_out_valid=1, then enter DRAIN.
REQ-019 pt_out_valid=1 outside WAIT SHALL be ignored.
REQ-020 A WAIT cycle counter reaching WAIT_MAX without pt_out_valid SHALL set err=1 and return to IDLE without asserting done.
REQ-021 DRAIN SHALL present x[0] first, out_valid=1, advancing the index only when out_ready=1.
REQ-022 out_last SHALL be 1 exactly when out_valid=1 and the index = N-1.
REQ-023 out_bit SHALL hold while out_valid=1 and out_ready=0.
REQ-024 The transfer of index N-1 SHALL pulse done for one cycle and return to IDLE; start is not accepted in that same cycle.
REQ-025 start SHALL be ignored when busy=1; frozen_mask changes after start SHALL have no effect.
REQ-026 An all-frozen mask SHALL pass through LOAD in exactly N cycles with in_ready never asserted.
REQ-027 Counters SHALL be $clog2(N) bits wide, plus one bit where a value of N must be represented; no wrap beyond N-1 is permitted.
REQ-028 err SHALL clear only on rst.

Reset
REQ-029 rst=1 SHALL, on the next edge, set the state to IDLE and all counters, u, x and mask registers to 0.
REQ-030 rst=1 SHALL, on the next edge, drive in_ready, pt_in_valid, out_valid, out_bit, out_last, busy, done and err to 0.
REQ-031 rst asserted mid-frame SHALL discard the frame, with no done pulse and no further out_valid.
REQ-032 rst SHALL take priority over start and over all handshakes in the same cycle.

Structure
REQ-033 Package polar_pkg SHALL hold the state enum type and a localparam-style width helper for $clog2(BITS).
REQ-034 The module SHALL contain no sub-module; the integration level SHALL instantiate it beside polar_transform of equal BITS.

Verification (BITS=8, transform x0=u0, x1=u0^u1 recursive, latency 1)
REQ-035 Mask 8'b0001_0111, info 1,1,1,1 with in_valid always 1 -> pt_u=[0,0,0,1,0,1,1,1]; serial out 0,0,0,1,0,1,1,0; out_last on the 8th bit; done is 1 pulse.
REQ-036 Same mask, info 1,0,1,1 with in_valid low for 3 cycles before each bit -> pt_u=[0,0,0,1,0,0,1,1]; out 0,0,0,1,0,0,1,1; LOAD lasts 8+12 cycles.
REQ-037 Mask 8'hFF -> in_ready never 1; FIRE 8 cycles after the start edge; out all zeros.
REQ-038 out_ready toggling 1,0,0,1,... during DRAIN -> each bit held while stalled; exactly 8 transfers occur.
REQ-039 pt_out_valid tied 0 -> err=1 after 4 WAIT cycles; state IDLE; no done.
REQ-040 rst during LOAD at pos 5, then a fresh start -> the new frame is correct and no stale bits appear.

Source files
------------

// File: rtl/polar_pkg.sv
// Shared types and helpers for the polar frame scheduler.
// Holds the FSM state type and the index-width helper.
package polar_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FIRE,
        S_WAIT,
        S_DRAIN
    } state_t;

    // Index width for an n-entry range; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/polar_frame_sched.sv
// Polar frame scheduler: assembles u from frozen mask and serial info
// bits, fires the transform, then streams the codeword out serially.
module polar_frame_sched
    import polar_pkg::*;
#(
    parameter int BITS     = 8,
    parameter int WAIT_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [BITS-1:0] frozen_mask,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_bit,
    output logic            pt_in_valid,
    output logic [BITS-1:0] pt_u,
    input  logic            pt_out_valid,
    input  logic [BITS-1:0] pt_x,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_bit,
    output logic            out_last,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam int PW = idx_w(BITS);
    localparam int WW = idx_w(WAIT_MAX);
    localparam logic [PW-1:0] POS_LAST = PW'(BITS - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_MAX - 1);

    state_t          state;
    logic [PW-1:0]   pos;
    logic [WW-1:0]   wcnt;
    logic [BITS-1:0] mask;
    logic [BITS-1:0] u;
    logic [BITS-1:0] x;
    logic            done_q;
    logic            err_q;

    // Frame sequencing: load u, fire, await result, drain codeword.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            pos    <= '0;
            wcnt   <= '0;
            mask   <= '0;
            u      <= '0;
            x      <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        mask  <= frozen_mask;
                        pos   <= '0;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Frozen slots advance on their own; info slots wait.
                    if (mask[pos] || in_valid) begin
                        u[pos] <= mask[pos] ? 1'b0 : in_bit;
                        if (pos == POS_LAST) begin
                            pos   <= '0;
                            state <= S_FIRE;
                        end else begin
                            pos <= pos + 1'b1;
                        end
                    end
                end
                S_FIRE: begin
                    wcnt  <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (pt_out_valid) begin
                        x     <= pt_x;
                        pos   <= '0;
                        state <= S_DRAIN;
                    end else if (wcnt == WAIT_LAST) begin
                        err_q <= 1'b1;
                        wcnt  <= '0;
                        state <= S_IDLE;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (pos == POS_LAST) begin
                            pos    <= '0;
                            done_q <= 1'b1;
                            state  <= S_IDLE;
                        end else begin
                            pos <= pos + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy        = (state != S_IDLE);
    assign in_ready    = (state == S_LOAD) && !mask[pos];
    assign pt_in_valid = (state == S_FIRE);
    assign pt_u        = u;
    assign out_valid   = (state == S_DRAIN);
    assign out_bit     = out_valid && x[pos];
    assign out_last    = out_valid && (pos == POS_LAST);
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_polar_frame_sched.sv
// Bench for polar_frame_sched with a behavioural transform and
// a reference model of frame assembly and encoding.
module tb_polar_frame_sched;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] frozen_mask;
    logic         in_valid;
    logic         in_ready;
    logic         in_bit;
    logic         pt_in_valid;
    logic [N-1:0] pt_u;
    logic         pt_out_valid;
    logic [N-1:0] pt_x;
    logic         out_valid;
    logic         out_ready;
    logic         out_bit;
    logic         out_last;
    logic         busy;
    logic         done;
    logic         err;

    logic         tr_en;
    logic         tr_valid;
    logic [N-1:0] tr_x;
    logic         noise_v;
    logic [N-1:0] noise_x;

    int n_cmp = 0;
    int n_bad = 0;

    logic [N-1:0] o_pu, o_bits, o_lastm;
    int o_fire, o_ready, o_done, o_xfer;
    int o_hold_bad, o_pu_bad, o_hang, o_err_k;

    polar_frame_sched #(.BITS(N), .WAIT_MAX(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .frozen_mask(frozen_mask),
        .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit),
        .pt_in_valid(pt_in_valid), .pt_u(pt_u),
        .pt_out_valid(pt_out_valid), .pt_x(pt_x),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_bit(out_bit), .out_last(out_last),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // x[j] is the XOR of every u[i] whose index bits are a subset of j.
    function automatic logic [N-1:0] ref_x(input logic [N-1:0] u);
        logic [N-1:0] r = '0;
        for (int j = 0; j < N; j++)
            for (int i = 0; i < N; i++)
                if ((i & j) == i) r[j] = r[j] ^ u[i];
        return r;
    endfunction

    function automatic logic [N-1:0] ref_u(input logic [N-1:0] m,
                                           input logic [N-1:0] info);
        logic [N-1:0] r = '0;
        int k = 0;
        for (int i = 0; i < N; i++)
            if (!m[i]) begin
                r[i] = info[k];
                k++;
            end
        return r;
    endfunction

    function automatic int nfree(input logic [N-1:0] m);
        int c = 0;
        for (int i = 0; i < N; i++) if (!m[i]) c++;
        return c;
    endfunction

    // Transform model, latency one cycle.
    always @(posedge clk) begin
        tr_valid <= pt_in_valid && tr_en;
        tr_x     <= ref_x(pt_u);
    end

    assign pt_out_valid = tr_valid | noise_v;
    assign pt_x = tr_valid ? tr_x : noise_x;

    task automatic drive_frame(input logic [N-1:0] m,
                               input logic [N-1:0] info,
                               input int gap, input int rmode,
                               input bit noise);
        int ii, gc, dc;
        bit fired, stalled;
        logic pb;
        o_pu = '0; o_bits = '0; o_lastm = '0;
        o_fire = -1; o_ready = 0; o_done = 0; o_xfer = 0;
        o_hold_bad = 0; o_pu_bad = 0; o_hang = 0; o_err_k = -1;
        ii = 0; gc = 0; dc = 0; fired = 0; stalled = 0; pb = 0;
        @(negedge clk);
        start = 1'b1;
        frozen_mask = m;
        @(negedge clk);
        start = 1'b0;
        o_hang = 1;
        for (int k = 0; k < 400; k++) begin
            if (!busy) begin
                o_hang = 0;
                break;
            end
            frozen_mask = N'($urandom);
            start = 1'($urandom % 2);
            if (pt_in_valid && !fired) begin
                fired = 1;
                o_fire = k;
                o_pu = pt_u;
            end
            if (fired && !out_valid && pt_u !== o_pu) o_pu_bad++;
            if (in_ready) begin
                o_ready++;
                if (gc >= gap && ii < N) begin
                    in_valid = 1'b1;
                    in_bit = info[ii];
                    ii++;
                    gc = 0;
                end else begin
                    in_valid = 1'b0;
                    gc++;
                end
            end else begin
                in_valid = 1'($urandom % 2);
                in_bit = 1'($urandom % 2);
            end
            noise_v = noise && !fired && ($urandom % 2 == 1);
            noise_x = N'($urandom);
            if (out_valid) begin
                if (stalled && out_bit !== pb) o_hold_bad++;
                case (rmode)
                    0: out_ready = 1'b1;
                    1: out_ready = (dc % 3 == 0);
                    default: out_ready = 1'($urandom % 2);
                endcase
                pb = out_bit;
                stalled = !out_ready;
                if (out_ready) begin
                    if (o_xfer < N) begin
                        o_bits[o_xfer] = out_bit;
                        o_lastm[o_xfer] = out_last;
                    end
                    o_xfer++;
                end
                dc++;
            end else begin
                out_ready = 1'($urandom % 2);
            end
            @(negedge clk);
            if (done) o_done++;
            if (err && o_err_k < 0) o_err_k = k + 1;
        end
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        noise_v = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done) o_done++;
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({busy, in_ready, pt_in_valid, out_valid} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_hs: got %b want 0000",
                     {busy, in_ready, pt_in_valid, out_valid});
        end
        n_cmp++;
        if ({out_bit, out_last, done, err} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 0000",
                     {out_bit, out_last, done, err});
        end
        n_cmp++;
        if (pt_u !== '0) begin
            n_bad++;
            $display("FAIL reset_u: got %h want 00", pt_u);
        end
    endtask

    task automatic test_basic();
        drive_frame(8'b0001_0111, 8'h0F, 0, 0, 0);
        n_cmp++;
        if (o_pu !== 8'hE8) begin
            n_bad++;
            $display("FAIL basic_pu: got %h want e8", o_pu);
        end
        n_cmp++;
        if (o_bits !== 8'h68) begin
            n_bad++;
            $display("FAIL basic_out: got %h want 68", o_bits);
        end
        n_cmp++;
        if (o_lastm !== 8'h80) begin
            n_bad++;
            $display("FAIL basic_last: got %h want 80", o_lastm);
        end
        n_cmp++;
        if (o_done !== 1 || o_fire !== 8) begin
            n_bad++;
            $display("FAIL basic_done_fire: got %0d/%0d want 1/8",
                     o_done, o_fire);
        end
    endtask

    task automatic test_input_stall();
        drive_frame(8'b0001_0111, 8'h0D, 3, 0, 0);
        n_cmp++;
        if (o_pu !== 8'hC8) begin
            n_bad++;
            $display("FAIL stall_pu: got %h want c8", o_pu);
        end
        n_cmp++;
        if (o_bits !== 8'hC8) begin
            n_bad++;
            $display("FAIL stall_out: got %h want c8", o_bits);
        end
        n_cmp++;
        if (o_fire !== 20) begin
            n_bad++;
            $display("FAIL stall_load_len: got %0d want 20", o_fire);
        end
    endtask

    task automatic test_all_frozen();
        drive_frame(8'hFF, N'($urandom), 1, 0, 0);
        n_cmp++;
        if (o_ready !== 0) begin
            n_bad++;
            $display("FAIL frozen_ready: got %0d want 0", o_ready);
        end
        n_cmp++;
        if (o_fire !== 8) begin
            n_bad++;
            $display("FAIL frozen_fire: got %0d want 8", o_fire);
        end
        n_cmp++;
        if (o_bits !== 8'h00 || o_done !== 1) begin
            n_bad++;
            $display("FAIL frozen_out: got %h/%0d want 00/1",
                     o_bits, o_done);
        end
    endtask

    task automatic test_out_stall();
        logic [N-1:0] m, info, ex;
        m = N'($urandom);
        info = N'($urandom);
        ex = ref_x(ref_u(m, info));
        drive_frame(m, info, 0, 1, 0);
        n_cmp++;
        if (o_xfer !== N || o_hold_bad !== 0) begin
            n_bad++;
            $display("FAIL ostall_xfer_hold: got %0d/%0d want 8/0",
                     o_xfer, o_hold_bad);
        end
        n_cmp++;
        if (o_bits !== ex) begin
            n_bad++;
            $display("FAIL ostall_out: got %h want %h", o_bits, ex);
        end
    endtask

    task automatic test_timeout();
        logic [N-1:0] m, info, ex;
        tr_en = 1'b0;
        drive_frame(8'h55, 8'h0A, 0, 0, 0);
        tr_en = 1'b1;
        n_cmp++;
        if (err !== 1'b1 || busy !== 1'b0 || o_done !== 0) begin
            n_bad++;
            $display("FAIL timeout_state: got err=%b busy=%b done=%0d want 1/0/0",
                     err, busy, o_done);
        end
        n_cmp++;
        if (o_err_k !== o_fire + 5) begin
            n_bad++;
            $display("FAIL timeout_len: got %0d want %0d",
                     o_err_k, o_fire + 5);
        end
        m = N'($urandom);
        info = N'($urandom);
        ex = ref_x(ref_u(m, info));
        drive_frame(m, info, 0, 0, 0);
        n_cmp++;
        if (err !== 1'b1 || o_bits !== ex) begin
            n_bad++;
            $display("FAIL timeout_sticky: got err=%b out=%h want 1/%h",
                     err, o_bits, ex);
        end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] info, ex;
        int dn;
        @(negedge clk);
        start = 1'b1;
        frozen_mask = '0;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        in_bit = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        n_cmp++;
        if ({busy, in_ready, out_valid, done, err} !== 5'b0) begin
            n_bad++;
            $display("FAIL midrst_flags: got %b want 00000",
                     {busy, in_ready, out_valid, done, err});
        end
        n_cmp++;
        if (pt_u !== '0) begin
            n_bad++;
            $display("FAIL midrst_u: got %h want 00", pt_u);
        end
        dn = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || out_valid) dn++;
        end
        n_cmp++;
        if (dn !== 0) begin
            n_bad++;
            $display("FAIL midrst_quiet: got %0d want 0", dn);
        end
        info = N'($urandom);
        ex = ref_x(ref_u(8'b0001_0111, info));
        drive_frame(8'b0001_0111, info, 0, 0, 0);
        n_cmp++;
        if (o_bits !== ex || o_done !== 1) begin
            n_bad++;
            $display("FAIL midrst_fresh: got %h/%0d want %h/1",
                     o_bits, o_done, ex);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] m, info, eu, ex;
        int gap;
        for (int t = 0; t < 12; t++) begin
            m = N'($urandom);
            info = N'($urandom);
            gap = int'($urandom_range(0, 2));
            eu = ref_u(m, info);
            ex = ref_x(eu);
            drive_frame(m, info, gap, 2, 1);
            n_cmp++;
            if (o_pu !== eu || o_bits !== ex) begin
                n_bad++;
                $display("FAIL rand_data[%0d]: got u=%h x=%h want u=%h x=%h",
                         t, o_pu, o_bits, eu, ex);
            end
            n_cmp++;
            if (o_fire !== N + nfree(m) * gap ||
                o_ready !== nfree(m) * (gap + 1)) begin
                n_bad++;
                $display("FAIL rand_load[%0d]: got %0d/%0d want %0d/%0d",
                         t, o_fire, o_ready, N + nfree(m) * gap,
                         nfree(m) * (gap + 1));
            end
            n_cmp++;
            if (o_lastm !== 8'h80 || o_done !== 1 || o_xfer !== N) begin
                n_bad++;
                $display("FAIL rand_end[%0d]: got %h/%0d/%0d want 80/1/8",
                         t, o_lastm, o_done, o_xfer);
            end
            n_cmp++;
            if (o_hold_bad !== 0 || o_pu_bad !== 0 || o_hang !== 0) begin
                n_bad++;
                $display("FAIL rand_stab[%0d]: got %0d/%0d/%0d want 0/0/0",
                         t, o_hold_bad, o_pu_bad, o_hang);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        frozen_mask = '0;
        in_valid = 1'b0;
        in_bit = 1'b0;
        out_ready = 1'b0;
        tr_en = 1'b1;
        noise_v = 1'b0;
        noise_x = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_basic();
        test_input_stall();
        test_all_frozen();
        test_out_stall();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
